// File: rtl/gpr_bank.sv
// rtl/gpr_bank.sv - 32-entry GPR bank with busy scoreboard and issue stall
module gpr_bank #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                    clock_in,
    input  logic                    reset_n_in,
    output logic [NREGS*XLEN-1:0]   regs_data_out,
    output logic [NREGS-1:0]        busy_out,
    input  logic [4:0]              rs1_addr_in,
    input  logic                    rs1_used_in,
    input  logic [4:0]              rs2_addr_in,
    input  logic                    rs2_used_in,
    input  logic                    issue_valid_in,
    input  logic [4:0]              issue_rd_in,
    output logic                    stall_out,
    output logic                    issue_ack_out,
    input  logic                    wb_valid_in,
    input  logic [4:0]              wb_rd_in,
    input  logic [XLEN-1:0]         wb_data_in,
    input  logic                    flush_in
);

    // x0 has no storage; entries 1..NREGS-1 only
    logic [NREGS-1:1][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]           busy_q, busy_d;

    logic wb_en;
    logic issue_set;

    // Stall uses registered busy only, so write-back never shortens a stall;
    // busy_q[0] is held at 0 so address 0 can never stall
    always_comb begin
        stall_out     = issue_valid_in &
                        ((rs1_used_in & busy_q[rs1_addr_in]) |
                         (rs2_used_in & busy_q[rs2_addr_in]) |
                         busy_q[issue_rd_in]);
        issue_ack_out = issue_valid_in & ~stall_out;
        wb_en         = wb_valid_in & (wb_rd_in != 5'd0);
        issue_set     = issue_ack_out & (issue_rd_in != 5'd0);
    end

    // Next register contents: write-back is unaffected by flush
    always_comb begin
        regs_d = regs_q;
        for (int k = 1; k < NREGS; k++) begin
            if (wb_en && (wb_rd_in == 5'(k))) begin
                regs_d[k] = wb_data_in;
            end
        end
    end

    // Next busy: wb clears, accepted issue sets (issue wins), flush clears all
    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_rd_in] = 1'b0;
        end
        if (issue_set) begin
            busy_d[issue_rd_in] = 1'b1;
        end
        if (flush_in) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign regs_data_out = {regs_q, {XLEN{1'b0}}};
    assign busy_out      = busy_q;

endmodule

// File: tb/tb_gpr_bank.sv
// tb/tb_gpr_bank.sv - directed vector bench for gpr_bank
module tb_gpr_bank;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1023:0] regs;
    logic [31:0]   busy;
    logic [4:0]    rs1, rs2, ird, wrd;
    logic          u1, u2, iv, wv, fl;
    logic [31:0]   wdata;
    logic          stall, ack;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gpr_bank #(.XLEN(32), .NREGS(32)) dut (
        .clock_in       (clk),
        .reset_n_in     (rst_n),
        .regs_data_out  (regs),
        .busy_out       (busy),
        .rs1_addr_in    (rs1),
        .rs1_used_in    (u1),
        .rs2_addr_in    (rs2),
        .rs2_used_in    (u2),
        .issue_valid_in (iv),
        .issue_rd_in    (ird),
        .stall_out      (stall),
        .issue_ack_out  (ack),
        .wb_valid_in    (wv),
        .wb_rd_in       (wrd),
        .wb_data_in     (wdata),
        .flush_in       (fl)
    );

    typedef struct {
        logic        wv;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic        fl;
        logic        e_stall;
        logic        e_ack;
        logic [4:0]  creg;
        logic [31:0] e_reg;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic a_wv, logic [4:0] a_wrd, logic [31:0] a_wd,
                                logic a_iv, logic [4:0] a_ird,
                                logic [4:0] a_r1, logic a_u1, logic [4:0] a_r2, logic a_u2,
                                logic a_fl, logic a_es, logic a_ea,
                                logic [4:0] a_creg, logic [31:0] a_ereg, logic [31:0] a_eb);
        vec_t v;
        v.wv = a_wv; v.wrd = a_wrd; v.wdata = a_wd; v.iv = a_iv; v.ird = a_ird;
        v.rs1 = a_r1; v.u1 = a_u1; v.rs2 = a_r2; v.u2 = a_u2; v.fl = a_fl;
        v.e_stall = a_es; v.e_ack = a_ea; v.creg = a_creg; v.e_reg = a_ereg; v.e_busy = a_eb;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] slice(logic [4:0] k);
        return regs[32*k +: 32];
    endfunction

    task automatic idle();
        wv = 0; wrd = 0; wdata = 0; iv = 0; ird = 0;
        rs1 = 0; u1 = 0; rs2 = 0; u2 = 0; fl = 0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        // Arbitrary inputs during reset must not disturb the cleared state
        wv = 1; wrd = 5'd3; wdata = 32'hA5A5A5A5; iv = 1; ird = 5'd4;
        repeat (2) @(posedge clk);
        #1;
        check("reset_regs", 64'(regs == '0), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;

        //                wv wrd wdata         iv ird r1 u1 r2 u2 fl st ak creg ereg          ebusy
        vecs.push_back(mk(1, 5,  32'hDEADBEEF, 0, 0,  0, 0, 0, 0, 0, 0, 0, 5,  32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(1, 0,  32'hFFFFFFFF, 1, 0,  0, 1, 0, 0, 0, 0, 1, 0,  32'h0,        32'h0));
        vecs.push_back(mk(0, 0,  32'h0,        1, 7,  0, 0, 0, 0, 0, 0, 1, 7,  32'h0,        32'h80));
        vecs.push_back(mk(0, 0,  32'h0,        1, 8,  7, 1, 0, 0, 0, 1, 0, 7,  32'h0,        32'h80));
        vecs.push_back(mk(0, 0,  32'h0,        1, 0,  7, 0, 0, 0, 0, 0, 1, 7,  32'h0,        32'h80));
        vecs.push_back(mk(1, 7,  32'h1234,     1, 8,  7, 1, 0, 0, 0, 1, 0, 7,  32'h1234,     32'h0));
        vecs.push_back(mk(0, 0,  32'h0,        1, 8,  7, 1, 0, 0, 0, 0, 1, 7,  32'h1234,     32'h100));
        vecs.push_back(mk(0, 0,  32'h0,        1, 10, 0, 0, 8, 1, 0, 1, 0, 10, 32'h0,        32'h100));
        vecs.push_back(mk(0, 0,  32'h0,        1, 9,  0, 0, 0, 0, 0, 0, 1, 9,  32'h0,        32'h300));
        vecs.push_back(mk(0, 0,  32'h0,        1, 9,  0, 0, 0, 0, 0, 1, 0, 9,  32'h0,        32'h300));
        vecs.push_back(mk(1, 9,  32'h99,       1, 9,  0, 0, 0, 0, 0, 1, 0, 9,  32'h99,       32'h100));
        vecs.push_back(mk(0, 0,  32'h0,        1, 9,  0, 0, 0, 0, 0, 0, 1, 9,  32'h99,       32'h300));
        vecs.push_back(mk(1, 12, 32'hC12,      1, 12, 0, 0, 0, 0, 0, 0, 1, 12, 32'hC12,      32'h1300));
        vecs.push_back(mk(0, 0,  32'h0,        0, 0,  0, 0, 0, 0, 1, 0, 0, 9,  32'h99,       32'h0));
        vecs.push_back(mk(1, 12, 32'hABC,      1, 12, 0, 0, 0, 0, 1, 0, 1, 12, 32'hABC,      32'h0));
        vecs.push_back(mk(0, 0,  32'h0,        1, 3,  0, 0, 0, 0, 0, 0, 1, 3,  32'h0,        32'h8));
        vecs.push_back(mk(0, 0,  32'h0,        1, 4,  0, 0, 0, 0, 0, 0, 1, 4,  32'h0,        32'h18));
        vecs.push_back(mk(0, 0,  32'h0,        1, 31, 0, 0, 0, 0, 0, 0, 1, 31, 32'h0,        32'h80000018));
        vecs.push_back(mk(0, 0,  32'h0,        1, 0,  31,1, 0, 0, 0, 1, 0, 31, 32'h0,        32'h80000018));
        vecs.push_back(mk(0, 0,  32'h0,        1, 3,  0, 0, 0, 0, 1, 1, 0, 5,  32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(0, 0,  32'h0,        1, 31, 3, 1, 4, 1, 0, 0, 1, 7,  32'h1234,     32'h80000000));
        vecs.push_back(mk(1, 31, 32'h31,       0, 0,  31,1, 0, 0, 0, 0, 0, 31, 32'h31,       32'h0));

        foreach (vecs[i]) begin
            wv = vecs[i].wv; wrd = vecs[i].wrd; wdata = vecs[i].wdata;
            iv = vecs[i].iv; ird = vecs[i].ird;
            rs1 = vecs[i].rs1; u1 = vecs[i].u1; rs2 = vecs[i].rs2; u2 = vecs[i].u2;
            fl = vecs[i].fl;
            #1;
            check($sformatf("v%0d_stall", i), 64'(stall), 64'(vecs[i].e_stall));
            check($sformatf("v%0d_ack", i), 64'(ack), 64'(vecs[i].e_ack));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_x%0d", i, vecs[i].creg), 64'(slice(vecs[i].creg)), 64'(vecs[i].e_reg));
            check($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
            check($sformatf("v%0d_x0", i), 64'(slice(5'd0)), 64'd0);
        end

        // Mid-operation asynchronous reset: make x6 busy, then reset between edges
        idle();
        iv = 1; ird = 5'd6;
        @(posedge clk);
        #1;
        idle();
        check("pre_reset_busy", 64'(busy), 64'h40);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_regs", 64'(regs == '0), 64'd1);
        check("async_reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wv = 1; wrd = 5'd5; wdata = 32'hDEADBEEF;
        #1;
        check("post_reset_x5_before_edge", 64'(slice(5'd5)), 64'd0);
        @(posedge clk);
        #1;
        idle();
        check("post_reset_x5", 64'(slice(5'd5)), 64'hDEADBEEF);
        check("post_reset_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpr_bank.md
# gpr_bank

Architectural register bank and issue scoreboard for the Core101 integer pipeline. It holds the 32 general-purpose registers x0–x31, takes one write-back per cycle, and drives all 32 register values in parallel into the 32-entry read multiplexers in decode. A per-register busy scoreboard tracks in-flight destination writes and raises a stall when an instruction would read, or re-target, a register with a pending write.

## Interface
Parameters:
- XLEN, 32, register width
- NREGS, 32, register count (fixed; addresses are 5 bits)

Ports:
- clock_in  input  1  single clock, rising edge
- reset_n_in  input  1  reset, asynchronous assert, active-low
- regs_data_out  output  NREGS*XLEN  flat register image; bits [32k+31:32k] = xk; top level splits it into x00..x31 mux inputs
- busy_out  output  NREGS  scoreboard; bit k set = write to xk pending; bit 0 always 0
- rs1_addr_in  input  5  source 1 of instruction in decode
- rs1_used_in  input  1  source 1 is read by the instruction
- rs2_addr_in  input  5  source 2 address
- rs2_used_in  input  1  source 2 is read by the instruction
- issue_valid_in  input  1  decode requests issue this cycle
- issue_rd_in  input  5  destination of issuing instruction (0 = no write)
- stall_out  output  1  issue blocked this cycle (combinational)
- issue_ack_out  output  1  issue accepted = issue_valid_in & ~stall_out
- wb_valid_in  input  1  write-back strobe
- wb_rd_in  input  5  write-back destination
- wb_data_in  input  XLEN  write-back value
- flush_in  input  1  synchronous pipeline flush; clears all busy bits

## Operation
- Storage: 31 XLEN-bit registers x1..x31. x0 has no storage; its regs_data_out slice is constant 0.
- Write-back: on a rising edge with wb_valid_in=1 and wb_rd_in≠0, x[wb_rd_in] ← wb_data_in, and busy[wb_rd_in] is cleared (unless issue sets it in the same cycle; see below). wb_rd_in=0 is ignored entirely.
- Scoreboard set: on an edge with issue_ack_out=1 and issue_rd_in≠0, busy[issue_rd_in] ← 1.
- Stall, combinational from registered busy only:
  - stall_out = issue_valid_in & ((rs1_used_in & busy[rs1_addr_in]) | (rs2_used_in & busy[rs2_addr_in]) | busy[issue_rd_in]).
  - The last term covers write-after-write: one outstanding write per register.
  - Address 0 never stalls.
  - stall_out=0 whenever issue_valid_in=0.
- No bypass. A register written at edge N is visible on regs_data_out after edge N. A write-back in the same cycle as a dependent read does not remove that cycle's stall.
- Simultaneous events on the same register k (k≠0):
  - Write-back and issue accepted in the same cycle: data is written and busy[k] ends 1 (issue wins). This is legal only because the WAW stall prevents a second producer. It arises only when the accepted issue targets k after busy[k] was already 0.
  - flush_in with write-back: data is written, busy[k]=0.
  - flush_in with accepted issue: flush wins, busy[k]=0.
- flush_in clears all busy bits on the edge where it is 1. Register data is unaffected, and a write-back on that edge is still performed.
- A write-back to a register whose busy bit is 0 (after a flush) writes the data normally.

## Timing
- Reset (reset_n_in=0, immediately and asynchronously): all registers = 0, busy_out = 0, therefore regs_data_out = 0. stall_out and issue_ack_out follow their combinational equations.
- Reset asserted mid-operation discards pending scoreboard state and register contents with no edge needed. On the first edge after release, normal operation resumes.
- Write-back latency: 1 edge to regs_data_out and busy_out.
- Issue to busy latency: 1 edge. The stall on a dependent instruction appears in the cycle after the producer's issue_ack_out.
- stall_out and issue_ack_out are combinational from the inputs and registered busy, with no path from wb_* inputs.

## Test plan
- Reset: drive arbitrary inputs, assert reset_n_in=0 between edges -> regs_data_out=0 and busy_out=0 immediately. After release, wb x5←0xDEADBEEF -> x5 slice reads 0xDEADBEEF next cycle.
- x0 protection: wb_rd_in=0 with data 0xFFFFFFFF, and issue rd=0 -> x0 slice stays 0, busy_out[0]=0, no stall for rs1=0 with rs1_used_in=1.
- RAW hazard:
  - Issue rd=7 (ack=1).
  - Next cycle, issue with rs1=7 and rs1_used_in=1 -> stall_out=1, ack=0.
  - wb x7←0x1234 -> stall holds that cycle and drops the following cycle, with x7=0x1234.
  - rs1_used_in=0 with the same address -> no stall.
- WAW: x9 busy, issue rd=9 with no sources -> stall_out=1. After wb x9, the issue is accepted and busy[9]=1 again.
- Same-cycle wb and issue on x12 (busy[12]=0, stale wb) -> x12 updated, busy[12]=1. Same case with flush_in=1 -> busy_out=0, x12 updated.
- Flush: set busy on x3, x4 and x31, pulse flush_in -> busy_out=0 next cycle. Stalls on those registers cease, and register values are unchanged.
